// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2 K=3 (7,5) convolutional encoder/decoder pair.
package viterbi_pkg;
   localparam int K          = 3;
   localparam int NUM_STATES = 4;
   localparam logic [2:0] G1 = 3'b111;
   localparam logic [2:0] G0 = 3'b101;

   // {s1,s0}; s1 is the most recent input bit
   typedef logic [1:0] state_t;

   function automatic logic [1:0] exp_sym(input state_t s, input logic u);
      logic [2:0] r;
      r = {u, s};
      return {^(r & G1), ^(r & G0)};
   endfunction

   function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] d;
      d = a ^ b;
      return {d[1] & d[0], d[1] ^ d[0]};
   endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties favour predecessor 0.
module viterbi_acs #(
   parameter int PM_W = 5
) (
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [1:0]      bm0,
   input  logic [1:0]      bm1,
   output logic [PM_W-1:0] pm_new,
   output logic            dec
);
   logic [PM_W-1:0] c0, c1;

   // metric spread is bounded, so the sums never wrap at PM_W bits
   assign c0     = pm0 + PM_W'(bm0);
   assign c1     = pm1 + PM_W'(bm1);
   assign dec    = (c1 < c0);
   assign pm_new = dec ? c1 : c0;
endmodule

// File: rtl/viterbi_hd_decoder.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2, register-exchange survivors.
// Define VITERBI_PM_OUT_EN to expose the registered normalized best path metric.
module viterbi_hd_decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [1:0]      y,
   output logic            out_valid,
   output logic            out_bit
`ifdef VITERBI_PM_OUT_EN
   ,
   output logic [PM_W-1:0] best_pm
`endif
);
   localparam int CNT_W = $clog2(TB_DEPTH);

   logic [NUM_STATES-1:0][PM_W-1:0]     pm, pm_acs, pm_nxt;
   // only D-1 bits are stored: the oldest bit of new_surv is consumed immediately
   logic [NUM_STATES-1:0][TB_DEPTH-2:0] surv;
   logic [NUM_STATES-1:0][TB_DEPTH-1:0] surv_nxt;
   logic [NUM_STATES-1:0]               dec;
   logic [CNT_W-1:0]                    cnt;
   logic                                all_msb;
   state_t                              best;
   logic [PM_W-1:0]                     best_val;

   for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
      localparam int   P0 = 2 * (ns % 2);
      localparam int   P1 = P0 + 1;
      localparam logic U  = ((ns / 2) != 0);
      logic [1:0] bm0, bm1;

      assign bm0 = hamming(y, exp_sym(state_t'(P0), U));
      assign bm1 = hamming(y, exp_sym(state_t'(P1), U));

      viterbi_acs #(.PM_W(PM_W)) u_acs (
         .pm0    (pm[P0]),
         .pm1    (pm[P1]),
         .bm0    (bm0),
         .bm1    (bm1),
         .pm_new (pm_acs[ns]),
         .dec    (dec[ns])
      );

      assign surv_nxt[ns] = {(dec[ns] ? surv[P1] : surv[P0]), U};
   end

   always_comb begin
      all_msb = 1'b1;
      for (int i = 0; i < NUM_STATES; i++) all_msb = all_msb & pm_acs[i][PM_W-1];
      pm_nxt = pm_acs;
      if (all_msb)
         for (int i = 0; i < NUM_STATES; i++) pm_nxt[i][PM_W-1] = 1'b0;
      best     = '0;
      best_val = pm_nxt[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (pm_nxt[i] < best_val) begin
            best     = state_t'(i);
            best_val = pm_nxt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_STATES; i++) pm[i] <= (i == 0) ? '0 : PM_W'(4);
         surv      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
`ifdef VITERBI_PM_OUT_EN
         best_pm   <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            pm <= pm_nxt;
            for (int i = 0; i < NUM_STATES; i++) surv[i] <= surv_nxt[i][TB_DEPTH-2:0];
            if (cnt != CNT_W'(TB_DEPTH-1)) cnt <= cnt + 1'b1;
            out_valid <= (cnt == CNT_W'(TB_DEPTH-1));
            out_bit   <= surv_nxt[best][TB_DEPTH-1];
`ifdef VITERBI_PM_OUT_EN
            best_pm   <= best_val;
`endif
         end
      end
   end
endmodule

// File: doc/viterbi_hd_decoder.md
# viterbi_hd_decoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7/5 octal: y[1]=u^s1^s0, y[0]=u^s0). Sits directly downstream of the convolutional encoder (or the channel model fed by it). It consumes one 2-bit code symbol per valid cycle and emits one decoded data bit per symbol after a fixed decision depth. Uses add-compare-select over 4 states with register-exchange survivor memory.

## Interface
- TB_DEPTH, 16: decision depth D in symbols (survivor register length); legal range 8..64.
- PM_W, 5: path-metric width in bits; minimum 5.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  y is a valid symbol this cycle.
- y  input  2  received symbol {y1,y0}, same bit order as the encoder output.
- out_valid  output  1  out_bit holds a decoded bit this cycle (single-cycle pulse per bit).
- out_bit  output  1  decoded data bit.

One clock; reset is asynchronous and active-high.

## Operation
- State s={s1,s0}, s1 = most recent input bit. Transition from {a,b} with input u goes to {u,a}, expected symbol {u^a^b, u^b}.
- Branch metric = Hamming distance between y and expected symbol (0..2).
- ACS per next state {u,a}: candidates from {a,0} and {a,1}; choose smaller PM+BM; tie selects predecessor {a,0}.
- Survivor update: new_surv[{u,a}] = {surv[pred][D-2:0], u}; MSB is oldest decision.
- Best state = minimum new PM; tie selects lowest state index.
- Normalization: if all four new PMs have MSB set, clear MSB of all four in the same update. Spread is bounded by 4, so PMs never wrap.
- Reset values: PM[0]=0, PM[1..3]=4, all survivors 0, symbol counter 0, out_valid=0, out_bit=0.
- No backpressure; in_valid may be deasserted on any cycle. Idle cycles hold all state.
- Symbol alignment is the integrator's job: in_valid is first asserted on the cycle the encoder output reflects its first post-reset input.

## Timing
- All updates occur on the rising clk edge when in_valid=1.
- Symbol counter saturates at D-1.
- On accepting symbol n with n ≥ D-1, out_valid=1 and out_bit=new_surv[best][D-1] in the following cycle. This equals decoded u(n-D+1).
- out_valid=0 in every cycle not immediately following an accepted symbol with n ≥ D-1.
- Throughput is 1 symbol/cycle. Latency is D symbols plus 1 cycle.
- rst asserted mid-stream clears everything immediately. The count restarts, and the first D-1 symbols after release produce no output.

## Configuration
- VITERBI_PM_OUT_EN
  - Defined: adds output best_pm [PM_W-1:0], the registered normalized minimum PM. It updates with out_bit on every accepted symbol, including while out_valid=0, and resets to 0.
  - Undefined: the port and its register are absent. Decoding behaviour is identical.

## Structure
- Package viterbi_pkg: G1=3'b111, G0=3'b101, K=3, NUM_STATES=4, state typedef, and function exp_sym(state,u) returning the expected 2-bit symbol. The encoder and the decoder share these.
- Sub-module viterbi_acs: one state's add-compare-select. Inputs are two PMs and two BMs; outputs are the new PM and the decision bit. Instantiated 4 times.

## Test plan
- Reset: hold rst high mid-stream → out_valid=0 and out_bit=0 immediately. After release, 15 symbols give no out_valid pulse; the 16th gives one pulse.
- All-zero stream: 40 symbols of 00 → first out_valid the cycle after symbol 15, out_bit=0 for all 25 outputs.
- Known pattern: u=1,0,1,1,0,0 encoded as 11,10,00,01,01,11, then 00 padding → decoded bits 1,0,1,1,0,0 in order.
- Error correction: 200-bit random u with one flipped bit in symbol 5, plus two more flips at least 20 symbols apart → output equals u exactly.
- Gapped input: the same stream with random 0–3 idle cycles between symbols → identical out_bit sequence, one out_valid pulse per accepted symbol n ≥ 15.
- Normalization: 500 uncorrelated random symbols, then a clean encoded stream → no PM overflow, max−min PM ≤ 4 at all times, and correct decoding resumes within 16 symbols of the clean segment.
